// File: rtl/pending_event_arbiter.sv
// Pending-event arbiter: captures request pulses into sticky pending bits
// and offers the lowest-numbered unmasked one over a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   req[N]       event pulses, each sets its pending bit
//   mask[N]      1 = bit is held back from being offered (stays pending)
//   clr_lost     clears the sticky lost flag
//   out_valid    an offer is presented on out_pos
//   out_ready    consumer accepts the current offer
//   out_pos      index of the offered pending bit
//   pending[N]   registered pending vector
//   served_count accepted offers, modulo 256
//   lost         sticky: a request hit a bit that was already pending
module pending_event_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic             clr_lost,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_pos,
    output logic [N-1:0]     pending,
    output logic [7:0]       served_count,
    output logic             lost
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] out_pos_q, out_pos_d;
    logic [7:0]       served_count_q, served_count_d;
    logic             lost_q, lost_d;

    logic             hs;
    logic [N-1:0]     clr;
    logic [N-1:0]     cand;
    logic [N-1:0]     rem;
    logic             collide;

    // Bit 0 has the highest priority, so scan downwards and let the
    // lowest set bit overwrite any higher one found earlier.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    assign out_valid    = (state_q == OFFER);
    assign out_pos      = out_pos_q;
    assign pending      = pending_q;
    assign served_count = served_count_q;
    assign lost         = lost_q;

    assign hs = out_valid & out_ready;

    always_comb begin
        clr = '0;
        for (int i = 0; i < N; i++) begin
            clr[i] = hs && (out_pos_q == IDX_W'(i));
        end
    end

    // Candidates come from the registered pending vector only; a request
    // arriving this cycle is not visible until the next one.
    assign cand    = pending_q & ~mask;
    assign rem     = cand & ~clr;
    assign collide = |(req & pending_q & ~clr);

    always_comb begin
        pending_d = (pending_q & ~clr) | req;
    end

    // A new collision takes precedence over a clear request.
    always_comb begin
        lost_d = lost_q;
        if (collide) begin
            lost_d = 1'b1;
        end else if (clr_lost) begin
            lost_d = 1'b0;
        end
    end

    always_comb begin
        state_d        = state_q;
        out_pos_d      = out_pos_q;
        served_count_d = served_count_q;
        unique case (state_q)
            IDLE: begin
                if (cand != '0) begin
                    out_pos_d = lowest_set(cand);
                    state_d   = OFFER;
                end
            end
            OFFER: begin
                // The offer is frozen until accepted, whatever happens to
                // mask or to higher-priority requests meanwhile.
                if (hs) begin
                    served_count_d = served_count_q + 8'd1;
                    if (rem != '0) begin
                        out_pos_d = lowest_set(rem);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            pending_q      <= '0;
            out_pos_q      <= '0;
            served_count_q <= '0;
            lost_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            out_pos_q      <= out_pos_d;
            served_count_q <= served_count_d;
            lost_q         <= lost_d;
        end
    end

endmodule

// File: tb/tb_pending_event_arbiter.sv
// Randomised and directed bench for pending_event_arbiter, checked against
// an event-level reference model.
module tb_pending_event_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] mask;
    logic       clr_lost;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_pos;
    logic [3:0] pending;
    logic [7:0] served_count;
    logic       lost;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit   m_pend [4];
    bit   m_valid;
    int   m_pos;
    int   m_count;
    bit   m_lost;
    int   m_accepts;

    pending_event_arbiter #(.N(4), .IDX_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .mask         (mask),
        .clr_lost     (clr_lost),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pos      (out_pos),
        .pending      (pending),
        .served_count (served_count),
        .lost         (lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int first_eligible(input bit p [4],
                                          input logic [3:0] m, input int skip);
        for (int i = 0; i < 4; i++) begin
            if (p[i] && !m[i] && i != skip) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] pend_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Advance model and DUT by one clock, then compare every output.
    task automatic step();
        bit n_pend [4];
        bit n_valid;
        int n_pos;
        int n_count;
        bit n_lost;
        bit hit;
        int taken;
        int pick;
        n_valid = m_valid;
        n_pos   = m_pos;
        n_count = m_count;
        n_lost  = m_lost;
        if (reset) begin
            foreach (n_pend[i]) n_pend[i] = 1'b0;
            n_valid   = 1'b0;
            n_pos     = 0;
            n_count   = 0;
            n_lost    = 1'b0;
            m_accepts = 0;
        end else begin
            taken = (m_valid && out_ready) ? m_pos : -1;
            hit = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (req[i] && m_pend[i] && i != taken) hit = 1'b1;
                n_pend[i] = (m_pend[i] && i != taken) || req[i];
            end
            if (m_valid) begin
                if (taken >= 0) begin
                    n_count = (m_count + 1) % 256;
                    m_accepts++;
                    pick = first_eligible(m_pend, mask, taken);
                    if (pick >= 0) n_pos = pick;
                    else n_valid = 1'b0;
                end
            end else begin
                pick = first_eligible(m_pend, mask, -1);
                if (pick >= 0) begin
                    n_valid = 1'b1;
                    n_pos   = pick;
                end
            end
            if (hit) n_lost = 1'b1;
            else if (clr_lost) n_lost = 1'b0;
        end
        @(posedge clk);
        #1;
        m_pend  = n_pend;
        m_valid = n_valid;
        m_pos   = n_pos;
        m_count = n_count;
        m_lost  = n_lost;
        chk("out_valid", out_valid, m_valid);
        chk("out_pos", out_pos, m_pos);
        chk("pending", pending, pend_vec());
        chk("served_count", served_count, m_count);
        chk("lost", lost, m_lost);
    endtask

    task automatic cyc(input logic [3:0] r, input logic [3:0] m,
                       input logic rdy, input logic cl, input logic rst);
        req       = r;
        mask      = m;
        out_ready = rdy;
        clr_lost  = cl;
        reset     = rst;
        step();
    endtask

    initial begin
        int guard;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_valid = 0; m_pos = 0; m_count = 0; m_lost = 0; m_accepts = 0;
        req = '0; mask = '0; out_ready = 0; clr_lost = 0; reset = 1;
        #1;

        // reset state
        cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_count", served_count, 8'd0);

        // two-bit pulse served back to back
        cyc(4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0);
        chk("s1_not_yet", out_valid, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        chk("s1_pos1", out_pos, 2'd1);
        cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        chk("s1_pos3", out_pos, 2'd3);
        chk("s1_valid_hold", out_valid, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        chk("s1_idle", out_valid, 1'b0);
        chk("s1_count", served_count, 8'd2);
        chk("s1_pend", pending, 4'b0000);

        // stall: offer held while a higher-priority bit arrives
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        cyc(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc((k == 2) ? 4'b0001 : 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
            chk("s2_hold_pos", out_pos, 2'd2);
        end
        cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        chk("s2_next_pos", out_pos, 2'd0);
        chk("s2_next_valid", out_valid, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        chk("s2_count", served_count, 8'd2);

        // masking
        cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
        cyc(4'b0011, 4'b0001, 1'b1, 1'b0, 1'b0);
        cyc(4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0);
        chk("s3_pos1", out_pos, 2'd1);
        cyc(4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0);
        chk("s3_pend", pending, 4'b0001);
        chk("s3_idle", out_valid, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("s3_unmask_valid", out_valid, 1'b1);
        chk("s3_unmask_pos", out_pos, 2'd0);

        // collisions and lost flag
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        cyc(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
        chk("s4_no_lost", lost, 1'b0);
        cyc(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
        chk("s4_lost", lost, 1'b1);
        cyc(4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0);
        chk("s4_set_wins", lost, 1'b1);
        cyc(4'b0000, 4'b0100, 1'b0, 1'b1, 1'b0);
        chk("s4_cleared", lost, 1'b0);

        // same-cycle clear and re-request
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        cyc(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        chk("s5_offer0", out_pos, 2'd0);
        cyc(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
        chk("s5_pend", pending, 4'b0001);
        chk("s5_lost", lost, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("s5_reoffer", out_valid, 1'b1);

        // counter wrap
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        guard = 0;
        while (m_accepts < 256 && guard < 2000) begin
            cyc(4'($urandom), 4'b0000, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        chk("s6_wrap_in_time", (m_accepts == 256) ? 1 : 0, 1);
        chk("s6_wrap_count", served_count, 8'd0);

        // reset while offering
        guard = 0;
        while (!m_valid && guard < 8) begin
            cyc(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        chk("s6_offering", out_valid, 1'b1);
        cyc(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1);
        chk("s6_rst_valid", out_valid, 1'b0);
        chk("s6_rst_pend", pending, 4'b0000);
        chk("s6_rst_lost", lost, 1'b0);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000,
                1'($urandom), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 199) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
